// File: rtl/fifoc_cmd_ctrl_pkg.sv
// Shared constants for the command-path sequencer: state codes reported on
// `so`, default frame length and timeout counter width.
package fifoc_ctrl_pkg;

  localparam int FRAME_LEN_DEF = 12;
  localparam int TMO_W         = 16;

  // ERR codes sit in the same 0x14.. range the parser uses for its own errors.
  localparam logic [7:0] SC_IDLE = 8'h00;
  localparam logic [7:0] SC_WAIT = 8'h01;
  localparam logic [7:0] SC_PARS = 8'h02;
  localparam logic [7:0] SC_PREL = 8'h03;
  localparam logic [7:0] SC_DISP = 8'h04;
  localparam logic [7:0] SC_CFGS = 8'h05;
  localparam logic [7:0] SC_CFGR = 8'h06;
  localparam logic [7:0] SC_DONE = 8'h07;
  localparam logic [7:0] SC_ERR0 = 8'h14;
  localparam logic [7:0] SC_ERR1 = 8'h15;
  localparam logic [7:0] SC_ERR2 = 8'h16;

  typedef enum logic [7:0] {
    S_IDLE = SC_IDLE,
    S_WAIT = SC_WAIT,
    S_PARS = SC_PARS,
    S_PREL = SC_PREL,
    S_DISP = SC_DISP,
    S_CFGS = SC_CFGS,
    S_CFGR = SC_CFGR,
    S_DONE = SC_DONE,
    S_ERR0 = SC_ERR0,
    S_ERR1 = SC_ERR1,
    S_ERR2 = SC_ERR2
  } state_t;

endpackage

// File: rtl/fifoc_cmd_ctrl_if.sv
// Handshake bundle between the sequencer (master), the command FIFO,
// the parser and the configuration targets (slave side).
interface fifoc_cmd_ctrl_if #(
  parameter int NUM_TGT = 4
);

  logic               enable;
  logic [7:0]         fifoc_cnt;
  logic               parse_fs;
  logic               parse_fd;
  logic [7:0]         kind_dev;
  logic [NUM_TGT-1:0] cfg_fs;
  logic [NUM_TGT-1:0] cfg_fd;

  modport master (
    input  enable, fifoc_cnt, parse_fd, kind_dev, cfg_fd,
    output parse_fs, cfg_fs
  );

  modport slave (
    output enable, fifoc_cnt, parse_fd, kind_dev, cfg_fd,
    input  parse_fs, cfg_fs
  );

endinterface

// File: rtl/fifoc_cmd_ctrl_tmo_cnt.sv
// Per-state handshake timer: cleared on every state change, counts while a
// handshake is pending, flags the last allowed cycle.
module tmo_cnt
  import fifoc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  // Count cycles spent in the current handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (run)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/fifoc_cmd_ctrl.sv
// Command-path sequencer: waits for a full frame in the command FIFO, runs
// the parser handshake, then the handshake of the target selected by the
// parsed device code. Timeouts are terminal; bad device codes drop the frame.
//
//   state | meaning
//   IDLE  | disabled, waiting for enable
//   WAIT  | enabled, waiting for a full frame in the FIFO
//   PARS  | parse_fs high, waiting for parse_fd
//   PREL  | parse_fs low, waiting for parse_fd to fall
//   DISP  | validate sel_code, pick target
//   CFGS  | cfg_fs[tgt] high, waiting for cfg_fd[tgt]
//   CFGR  | cfg_fs low, waiting for cfg_fd[tgt] to fall
//   DONE  | frame applied, bump frame_cnt
//   ERR0  | parser handshake timeout (terminal)
//   ERR1  | invalid device code, bump drop_cnt
//   ERR2  | target handshake timeout (terminal)
module fifoc_cmd_ctrl
  import fifoc_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int NUM_TGT   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  fifoc_cmd_ctrl_if.master        bus,
  output logic                    busy,
  output logic                    err,
  output logic [7:0]              frame_cnt,
  output logic [7:0]              drop_cnt,
  output logic [7:0]              so
);

  localparam int         TGT_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [7:0] FRAME_B = 8'(FRAME_LEN);
  localparam logic [7:0] NUM_B   = 8'(NUM_TGT);

  state_t           state, state_nx;
  logic [7:0]       sel_code;
  logic [TGT_W-1:0] tgt;
  logic             code_ok;
  logic             tmo_run;
  logic             tmo_exp;

  assign code_ok = (sel_code != 8'd0) && (sel_code <= NUM_B);
  assign tmo_run = (state == S_PARS) || (state == S_PREL) ||
                   (state == S_CFGS) || (state == S_CFGR);

  tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_nx != state),
    .run     (tmo_run),
    .expired (tmo_exp)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state; an awaited condition always beats a same-cycle timeout.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.enable) state_nx = S_WAIT;
      S_WAIT: begin
        if (!bus.enable)                  state_nx = S_IDLE;
        else if (bus.fifoc_cnt >= FRAME_B) state_nx = S_PARS;
      end
      S_PARS: begin
        if (bus.parse_fd)  state_nx = S_PREL;
        else if (tmo_exp)  state_nx = S_ERR0;
      end
      S_PREL: begin
        if (!bus.parse_fd) state_nx = S_DISP;
        else if (tmo_exp)  state_nx = S_ERR0;
      end
      S_DISP: state_nx = code_ok ? S_CFGS : S_ERR1;
      S_CFGS: begin
        if (bus.cfg_fd[tgt])  state_nx = S_CFGR;
        else if (tmo_exp)     state_nx = S_ERR2;
      end
      S_CFGR: begin
        if (!bus.cfg_fd[tgt]) state_nx = S_DONE;
        else if (tmo_exp)     state_nx = S_ERR2;
      end
      S_DONE: state_nx = S_WAIT;
      S_ERR1: state_nx = S_WAIT;
      default: state_nx = state;
    endcase
  end

  // Output decode straight from the registered state.
  always_comb begin
    bus.parse_fs = (state == S_PARS);
    bus.cfg_fs   = '0;
    if (state == S_CFGS) bus.cfg_fs[tgt] = 1'b1;
    busy = (state != S_IDLE) && (state != S_WAIT);
    err  = (state == S_ERR0) || (state == S_ERR2);
    so   = state;
  end

  // Device code capture and target selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_code <= '0;
      tgt      <= '0;
    end else begin
      if ((state == S_PARS) && bus.parse_fd) sel_code <= bus.kind_dev;
      if ((state == S_DISP) && code_ok)      tgt      <= TGT_W'(sel_code - 8'd1);
    end
  end

  // Applied / dropped frame counters, free wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (state == S_DONE) frame_cnt <= frame_cnt + 8'd1;
      if (state == S_ERR1) drop_cnt  <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifoc_cmd_ctrl.sv
// Bench for fifoc_cmd_ctrl: parser/target peers driven from tasks, expected
// behaviour computed from the frame rules (valid code -> one-hot start and
// frame count, otherwise drop count).
module tb_fifoc_cmd_ctrl;

  localparam int NT  = 4;
  localparam int TMO = 64;
  localparam int FL  = 12;

  typedef struct {
    bit          tmo;
    bit          pfs_fall_ok;
    logic [NT-1:0] cfg_val;
    bit          hold_ok;
    bit          cfgr_ok;
    logic [7:0]  end_so;
    logic [7:0]  end_frame;
    logic [7:0]  end_drop;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       busy, err;
  logic [7:0] frame_cnt, drop_cnt, so;

  int total = 0;
  int bad   = 0;
  int exp_frame = 0;
  int exp_drop  = 0;

  fifoc_cmd_ctrl_if #(.NUM_TGT(NT)) bus_if ();

  fifoc_cmd_ctrl #(.FRAME_LEN(FL), .NUM_TGT(NT), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .busy      (busy),
    .err       (err),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .so        (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit dev_ok(input logic [7:0] kd);
    return (kd >= 8'd1) && (kd <= 8'(NT));
  endfunction

  function automatic logic [NT-1:0] onehot(input logic [7:0] kd);
    logic [NT-1:0] r;
    r = '0;
    if (dev_ok(kd)) r = NT'(1) << (int'(kd) - 1);
    return r;
  endfunction

  task automatic idle_inputs();
    bus_if.enable    = 1'b0;
    bus_if.fifoc_cnt = 8'd0;
    bus_if.parse_fd  = 1'b0;
    bus_if.kind_dev  = 8'd0;
    bus_if.cfg_fd    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    exp_frame = 0;
    exp_drop  = 0;
  endtask

  // Drives one frame through a well-behaved parser and target; returns what
  // was observed so the caller can compare against its expectations.
  task automatic run_frame(input logic [7:0] kd, input int p_lat, input int c_lat,
                           input bit rand_en, output obs_t o);
    int n;
    logic [NT-1:0] oh, noise;
    o.tmo = 1'b0; o.pfs_fall_ok = 1'b0; o.cfg_val = '0; o.hold_ok = 1'b1;
    o.cfgr_ok = 1'b1; o.end_so = 8'hff; o.end_frame = 8'hff; o.end_drop = 8'hff;
    oh = onehot(kd);
    bus_if.fifoc_cnt = 8'(FL + $urandom_range(0, 20));
    bus_if.enable = 1'b1;
    n = 0;
    while (!bus_if.parse_fs && n < 20) begin tick(); n++; end
    if (!bus_if.parse_fs) begin o.tmo = 1'b1; return; end
    repeat (p_lat) tick();
    bus_if.parse_fd = 1'b1;
    bus_if.kind_dev = kd;
    tick();
    o.pfs_fall_ok = !bus_if.parse_fs;
    if (rand_en) begin
      bus_if.enable    = 1'($urandom_range(0, 1));
      bus_if.fifoc_cnt = 8'($urandom_range(0, 30));
    end
    bus_if.parse_fd = 1'b0;
    bus_if.kind_dev = 8'($urandom);
    tick();
    tick();
    o.cfg_val = bus_if.cfg_fs;
    if (dev_ok(kd)) begin
      for (int i = 0; i < c_lat; i++) begin
        noise = NT'($urandom) & ~oh;
        bus_if.cfg_fd = noise;
        if (bus_if.cfg_fs !== oh) o.hold_ok = 1'b0;
        tick();
      end
      if (bus_if.cfg_fs !== oh) o.hold_ok = 1'b0;
      bus_if.cfg_fd = oh | (NT'($urandom) & ~oh);
      tick();
      o.cfgr_ok = (bus_if.cfg_fs === '0) && (so === 8'h06);
      bus_if.cfg_fd = NT'($urandom) & ~oh;
      tick();
      tick();
    end else begin
      tick();
    end
    bus_if.cfg_fd = '0;
    o.end_so    = so;
    o.end_frame = frame_cnt;
    o.end_drop  = drop_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick(); tick();
    total++; if (so !== 8'h00) begin bad++; $display("FAIL reset_so got=%h exp=00", so); end
    total++; if (bus_if.parse_fs !== 1'b0) begin bad++; $display("FAIL reset_parse_fs got=%b exp=0", bus_if.parse_fs); end
    total++; if (bus_if.cfg_fs !== 4'b0) begin bad++; $display("FAIL reset_cfg_fs got=%b exp=0000", bus_if.cfg_fs); end
    total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err got=%b exp=00", {busy, err}); end
    total++; if ({frame_cnt, drop_cnt} !== 16'h0) begin bad++; $display("FAIL reset_counters got=%h exp=0000", {frame_cnt, drop_cnt}); end
    rst = 1'b0;
    tick(); tick();
    total++; if (so !== 8'h00) begin bad++; $display("FAIL idle_hold_so got=%h exp=00", so); end
  endtask

  task automatic test_normal_frame();
    obs_t o;
    do_reset();
    run_frame(8'h02, 16, 5, 1'b0, o);
    exp_frame++;
    total++; if (o.tmo !== 1'b0) begin bad++; $display("FAIL normal_start got=no_parse_fs exp=parse_fs"); end
    total++; if (o.pfs_fall_ok !== 1'b1) begin bad++; $display("FAIL normal_pfs_fall got=%b exp=1", o.pfs_fall_ok); end
    total++; if (o.cfg_val !== 4'b0010) begin bad++; $display("FAIL normal_cfg_fs got=%b exp=0010", o.cfg_val); end
    total++; if (o.hold_ok !== 1'b1) begin bad++; $display("FAIL normal_cfg_hold got=%b exp=1", o.hold_ok); end
    total++; if (o.cfgr_ok !== 1'b1) begin bad++; $display("FAIL normal_cfg_release got=%b exp=1", o.cfgr_ok); end
    total++; if (o.end_so !== 8'h01) begin bad++; $display("FAIL normal_end_so got=%h exp=01", o.end_so); end
    total++; if (o.end_frame !== 8'(exp_frame)) begin bad++; $display("FAIL normal_frame_cnt got=%0d exp=%0d", o.end_frame, exp_frame); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL normal_err got=%b exp=0", err); end
  endtask

  task automatic test_short_fifo();
    int hi;
    do_reset();
    bus_if.enable = 1'b1;
    bus_if.fifoc_cnt = 8'd11;
    hi = 0;
    repeat (200) begin tick(); if (bus_if.parse_fs) hi++; end
    total++; if (hi !== 0) begin bad++; $display("FAIL short_parse_fs got=%0d exp=0", hi); end
    total++; if (so !== 8'h01) begin bad++; $display("FAIL short_so got=%h exp=01", so); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL short_busy got=%b exp=0", busy); end
  endtask

  task automatic test_parser_timeout();
    int n, hi;
    do_reset();
    bus_if.enable = 1'b1;
    bus_if.fifoc_cnt = 8'd12;
    n = 0;
    while (!bus_if.parse_fs && n < 20) begin tick(); n++; end
    total++; if (bus_if.parse_fs !== 1'b1) begin bad++; $display("FAIL ptmo_start got=%b exp=1", bus_if.parse_fs); end
    hi = 0;
    while (bus_if.parse_fs && hi < 200) begin hi++; tick(); end
    total++; if (hi !== TMO) begin bad++; $display("FAIL ptmo_width got=%0d exp=%0d", hi, TMO); end
    total++; if (so !== 8'h14) begin bad++; $display("FAIL ptmo_so got=%h exp=14", so); end
    total++; if ({err, busy} !== 2'b11) begin bad++; $display("FAIL ptmo_err_busy got=%b exp=11", {err, busy}); end
    repeat (20) tick();
    total++; if (so !== 8'h14 || err !== 1'b1) begin bad++; $display("FAIL ptmo_hold got=%h/%b exp=14/1", so, err); end
    total++; if (bus_if.parse_fs !== 1'b0) begin bad++; $display("FAIL ptmo_start_low got=%b exp=0", bus_if.parse_fs); end
    rst = 1'b1;
    #1;
    total++; if ({so, err, busy, bus_if.parse_fs} !== 11'h0) begin bad++; $display("FAIL ptmo_reset got=%h exp=000", {so, err, busy, bus_if.parse_fs}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_cfg_timeout();
    int n, hi;
    do_reset();
    bus_if.enable = 1'b1;
    bus_if.fifoc_cnt = 8'd12;
    n = 0;
    while (!bus_if.parse_fs && n < 20) begin tick(); n++; end
    bus_if.parse_fd = 1'b1; bus_if.kind_dev = 8'd1;
    tick();
    bus_if.parse_fd = 1'b0;
    tick(); tick();
    hi = 0;
    while (bus_if.cfg_fs == 4'b0001 && hi < 200) begin hi++; tick(); end
    total++; if (hi !== TMO) begin bad++; $display("FAIL ctmo_width got=%0d exp=%0d", hi, TMO); end
    total++; if (so !== 8'h16 || err !== 1'b1) begin bad++; $display("FAIL ctmo_state got=%h/%b exp=16/1", so, err); end
  endtask

  task automatic test_invalid_device();
    obs_t o;
    logic [7:0] codes [2];
    do_reset();
    codes[0] = 8'h00;
    codes[1] = 8'h05;
    for (int i = 0; i < 2; i++) begin
      run_frame(codes[i], 3 + i, 0, 1'b0, o);
      exp_drop++;
      total++; if (o.cfg_val !== 4'b0) begin bad++; $display("FAIL inv_cfg_fs code=%h got=%b exp=0000", codes[i], o.cfg_val); end
      total++; if (o.end_so !== 8'h01) begin bad++; $display("FAIL inv_end_so code=%h got=%h exp=01", codes[i], o.end_so); end
      total++; if (o.end_drop !== 8'(exp_drop)) begin bad++; $display("FAIL inv_drop_cnt got=%0d exp=%0d", o.end_drop, exp_drop); end
    end
    total++; if (err !== 1'b0 || frame_cnt !== 8'd0) begin bad++; $display("FAIL inv_err_frame got=%b/%0d exp=0/0", err, frame_cnt); end
  endtask

  task automatic test_race();
    int n;
    do_reset();
    bus_if.enable = 1'b1;
    bus_if.fifoc_cnt = 8'd12;
    n = 0;
    while (!bus_if.parse_fs && n < 20) begin tick(); n++; end
    bus_if.parse_fd = 1'b1; bus_if.kind_dev = 8'd3;
    tick();
    bus_if.parse_fd = 1'b0;
    tick(); tick();
    total++; if (bus_if.cfg_fs !== 4'b0100) begin bad++; $display("FAIL race_cfg_fs got=%b exp=0100", bus_if.cfg_fs); end
    repeat (TMO - 1) tick();
    bus_if.cfg_fd = 4'b0100;
    tick();
    total++; if (so !== 8'h06 || err !== 1'b0) begin bad++; $display("FAIL race_state got=%h/%b exp=06/0", so, err); end
    bus_if.cfg_fd = '0;
    tick(); tick();
    total++; if (frame_cnt !== 8'd1 || so !== 8'h01) begin bad++; $display("FAIL race_done got=%0d/%h exp=1/01", frame_cnt, so); end
  endtask

  task automatic test_reset_mid_frame();
    obs_t o;
    int n;
    do_reset();
    run_frame(8'd1, 2, 2, 1'b0, o);
    run_frame(8'd9, 1, 0, 1'b0, o);
    bus_if.fifoc_cnt = 8'd12;
    bus_if.enable = 1'b1;
    n = 0;
    while (!bus_if.parse_fs && n < 20) begin tick(); n++; end
    bus_if.parse_fd = 1'b1; bus_if.kind_dev = 8'd4;
    tick();
    bus_if.parse_fd = 1'b0;
    tick(); tick();
    total++; if (bus_if.cfg_fs !== 4'b1000) begin bad++; $display("FAIL rmid_cfg_fs got=%b exp=1000", bus_if.cfg_fs); end
    total++; if (frame_cnt !== 8'd1 || drop_cnt !== 8'd1) begin bad++; $display("FAIL rmid_pre_cnt got=%0d/%0d exp=1/1", frame_cnt, drop_cnt); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus_if.cfg_fs !== 4'b0) begin bad++; $display("FAIL rmid_async_cfg_fs got=%b exp=0000", bus_if.cfg_fs); end
    total++; if ({so, frame_cnt, drop_cnt} !== 24'h0) begin bad++; $display("FAIL rmid_async_state got=%h exp=000000", {so, frame_cnt, drop_cnt}); end
    tick();
    rst = 1'b0;
    exp_frame = 0; exp_drop = 0;
    run_frame(8'd4, 7, 3, 1'b0, o);
    exp_frame++;
    total++; if (o.cfg_val !== 4'b1000 || o.cfgr_ok !== 1'b1) begin bad++; $display("FAIL rmid_fresh_cfg got=%b/%b exp=1000/1", o.cfg_val, o.cfgr_ok); end
    total++; if (o.end_frame !== 8'(exp_frame)) begin bad++; $display("FAIL rmid_fresh_cnt got=%0d exp=%0d", o.end_frame, exp_frame); end
  endtask

  task automatic test_random_frames();
    obs_t o;
    logic [7:0] kd;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      kd = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      run_frame(kd, $urandom_range(0, 40), $urandom_range(0, 40), 1'b1, o);
      if (dev_ok(kd)) exp_frame++;
      else            exp_drop++;
      total++; if (o.tmo !== 1'b0) begin bad++; $display("FAIL rnd_start i=%0d got=no_parse_fs exp=parse_fs", i); end
      total++; if (o.pfs_fall_ok !== 1'b1) begin bad++; $display("FAIL rnd_pfs_fall i=%0d got=0 exp=1", i); end
      total++; if (o.cfg_val !== onehot(kd)) begin bad++; $display("FAIL rnd_cfg_fs i=%0d kd=%h got=%b exp=%b", i, kd, o.cfg_val, onehot(kd)); end
      total++; if (o.hold_ok !== 1'b1 || o.cfgr_ok !== 1'b1) begin bad++; $display("FAIL rnd_cfg_hs i=%0d got=%b%b exp=11", i, o.hold_ok, o.cfgr_ok); end
      total++; if (o.end_so !== 8'h01) begin bad++; $display("FAIL rnd_end_so i=%0d got=%h exp=01", i, o.end_so); end
      total++; if (o.end_frame !== 8'(exp_frame) || o.end_drop !== 8'(exp_drop)) begin
        bad++; $display("FAIL rnd_counts i=%0d got=%0d/%0d exp=%0d/%0d", i, o.end_frame, o.end_drop, exp_frame, exp_drop);
      end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", err); end
  endtask

  task automatic test_drop_wrap();
    obs_t o;
    int fails;
    do_reset();
    fails = 0;
    for (int i = 0; i < 258; i++) begin
      run_frame(8'd0, 0, 0, 1'b0, o);
      exp_drop++;
      if (o.tmo) fails++;
    end
    total++; if (fails !== 0) begin bad++; $display("FAIL wrap_starts got=%0d exp=0", fails); end
    total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL wrap_drop_cnt got=%0d exp=%0d", drop_cnt, 8'(exp_drop)); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_normal_frame();
    test_short_fifo();
    test_parser_timeout();
    test_cfg_timeout();
    test_invalid_device();
    test_race();
    test_reset_mid_frame();
    test_random_frames();
    test_drop_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifoc_cmd_ctrl.md
# fifoc_cmd_ctrl

Command-path sequencer that sits between the command FIFO and the FIFO-to-register parser. It waits for a complete command frame in the FIFO, then starts the parser with the fs/fd handshake. It decodes the parsed `kind_dev` into a one-hot configuration request and sequences that target's own fs/fd handshake. Timeouts and malformed device codes are reported on `err`/`so` and counted.

## Interface
- `FRAME_LEN`, 12: bytes per command frame (2 header + 9 command + 1 check).
- `NUM_TGT`, 4: number of configurable targets; valid `kind_dev` is 1..NUM_TGT.
- `TIMEOUT`, 1024: cycles allowed in any handshake state before error (≥2, ≤65535).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active high.
- `enable` in 1: allow new frames to start.
- `fifoc_cnt` in 8: bytes currently held in the command FIFO.
- `parse_fs` out 1: start to parser; high only in PARS.
- `parse_fd` in 1: parser done.
- `kind_dev` in 8: device code from parser, valid while `parse_fd` is high.
- `cfg_fs` out NUM_TGT: one-hot start to the selected target; high only in CFGS.
- `cfg_fd` in NUM_TGT: per-target done.
- `busy` out 1: high in every state except IDLE and WAIT.
- `err` out 1: sticky timeout flag.
- `frame_cnt` out 8: frames fully applied (wraps 255→0).
- `drop_cnt` out 8: frames dropped for invalid `kind_dev` (wraps).
- `so` out 8: current state code.

## Operation
- **State codes:** IDLE=00, WAIT=01, PARS=02, PREL=03, DISP=04, CFGS=05, CFGR=06, DONE=07, ERR0=14, ERR1=15, ERR2=16.
- **IDLE:** go to WAIT when `enable` is high.
- **WAIT:**
  - Go to IDLE if `enable` is low.
  - Otherwise go to PARS when `fifoc_cnt >= FRAME_LEN`.
- **PARS:** `parse_fs`=1.
  - When `parse_fd` is high: capture `kind_dev` into `sel_code` and go to PREL.
  - On timeout: go to ERR0.
- **PREL:** `parse_fs`=0.
  - When `parse_fd` is low: go to DISP.
  - On timeout: go to ERR0.
- **DISP:**
  - If `sel_code` is 0 or greater than NUM_TGT: go to ERR1.
  - Otherwise: register `tgt = sel_code-1` and go to CFGS.
- **CFGS:** `cfg_fs[tgt]`=1; all other bits are 0.
  - When `cfg_fd[tgt]` is high: go to CFGR.
  - On timeout: go to ERR2.
  - Other `cfg_fd` bits are ignored.
- **CFGR:** `cfg_fs`=0.
  - When `cfg_fd[tgt]` is low: go to DONE.
  - On timeout: go to ERR2.
- **DONE:** `frame_cnt`+1, then go to WAIT.
- **ERR1:** `drop_cnt`+1, then go to WAIT. This state lasts one cycle and does not set `err`.
- **ERR0 / ERR2:** terminal; leave only on `rst`. `err`=1 and all starts are 0.
- **Enable:** `enable` is sampled only in IDLE and WAIT. Dropping it mid-frame does not abort the frame.
- **Timeout counter:** 16-bit; clears on every state change and increments in PARS, PREL, CFGS and CFGR.
  - Timeout fires when the counter equals TIMEOUT-1 and the awaited condition is false.
  - If the condition and the timeout occur in the same cycle, the condition wins and there is no error.
- **Counters:** 8-bit, wrap-around, no saturation.

## Timing
- **Reset values:** state IDLE, `so`=00, `parse_fs`=0, `cfg_fs`=0, `busy`=0, `err`=0, `frame_cnt`=0, `drop_cnt`=0, `sel_code`=0, `tgt`=0, timer=0.
- **Output types:**
  - `parse_fs`, `cfg_fs`, `busy`, `err` and `so` are decoded combinationally from the registered state.
  - Counters are registered.
- **Latencies:**
  - WAIT condition true at cycle N: `parse_fs` rises at N+1.
  - `parse_fd` sampled high at cycle M: `parse_fs` falls at M+1.
  - Minimum cycles from `parse_fd` low to `cfg_fs` high: 2 (DISP, then CFGS).
  - `frame_cnt` updates on the clock edge leaving DONE and is visible one cycle after DONE.
- **Handshake rule:** a start stays high until its done is seen, then falls. The block waits for done to fall before any further action. Peer must not raise done without a start.
- **Minimum frame time:** 6 cycles plus the peer latencies.
- **Reset mid-operation:** starts drop immediately (asynchronous path to state). Peers see the start fall without a handshake and must return to idle by themselves.

## Structure
- **Package `fifoc_ctrl_pkg`:** 8-bit state code constants (including the ERR codes that match the parser's error range), default FRAME_LEN, TIMEOUT counter width (16).
- **Sub-module `tmo_cnt`:**
  - Inputs: `clk`, `rst`, `clr`, `run`.
  - Output: `expired` when count = TIMEOUT-1.
  - Parameterised by TIMEOUT.
- **Top level:** state register, next-state logic, `sel_code`/`tgt` registers, counters, and output decode. Target 120–250 lines.

## Test plan
- **Normal frame:** `fifoc_cnt`=12, `enable`=1; parser model raises `parse_fd` after 16 cycles with `kind_dev`=02; target 1 raises done after 5 cycles.
  - `cfg_fs`=4'b0010 until done, then 0.
  - `frame_cnt`=1, `err`=0, final `so`=01.
- **Short FIFO:** `fifoc_cnt`=11 for 200 cycles → `parse_fs` stays 0, `so`=01.
- **Parser timeout:** TIMEOUT=64; parser never responds.
  - `parse_fs` high for exactly 64 cycles, then `so`=14 and `err`=1.
  - State holds until `rst`, after which everything is 0.
- **Invalid device:** `kind_dev`=00, then a second frame with `kind_dev`=05 (NUM_TGT=4).
  - `drop_cnt`=2, `cfg_fs` never asserted, `err`=0, block returns to WAIT each time.
- **Same-cycle race:** `cfg_fd[tgt]` rises in the same cycle as the timeout → proceeds to CFGR, no ERR2, `frame_cnt` increments.
- **Reset mid-frame:** assert `rst` while in CFGS → `cfg_fs`=0 asynchronously, `so`=00, counters 0. A fresh frame after release completes normally.
